adc_axis_packer: RTL and testbench
==================================

# adc_axis_packer

Capture-side counterpart of the AWG stream path: takes parallel two-channel Zmod ADC samples and emits them as a framed AXI-Stream of 32-bit words toward DMA/memory. Data are packed in the same lane layout the DAC stream consumes, so a captured frame can be replayed unchanged. A software-armed capture of a fixed number of samples passes through an internal FIFO that absorbs downstream backpressure. Samples lost to a full FIFO are flagged by a sticky overflow.

## Interface
- ZMOD_DATA_SIZE, 14, ADC sample width per channel
- AXIS_DATA_SIZE, 32, output word width; must equal 2*16
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥4
- LEN_WIDTH, 16, width of frame length
- i_sys_clock  in  1  single clock for all logic
- i_nReset  in  1  asynchronous, active-low reset
- i_adc_ch1  in  ZMOD_DATA_SIZE  channel 1 sample, two's complement
- i_adc_ch2  in  ZMOD_DATA_SIZE  channel 2 sample, two's complement
- i_adc_valid  in  1  sample pair valid this cycle; no backpressure on this side
- i_start  in  1  arm a capture (level sampled each cycle)
- i_frame_len  in  LEN_WIDTH  samples per frame, latched on accepted start
- o_data  out  AXIS_DATA_SIZE  AXIS tdata
- o_data_valid  out  1  AXIS tvalid
- i_data_ready  in  1  AXIS tready
- o_data_last  out  1  AXIS tlast, on final word of frame
- o_busy  out  1  high in CAPTURE or DRAIN
- o_done  out  1  one-cycle pulse when a frame has fully left the block
- o_overflow  out  1  sticky: at least one sample dropped this frame

## Operation
- Packing: o_data[31:18]=ch1, o_data[17:16]=0, o_data[15:2]=ch2, o_data[1:0]=0. No arithmetic on sample values.
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE: i_start=1 and i_frame_len≠0 → latch length into remaining counter, clear o_overflow, go CAPTURE. i_start with i_frame_len=0 is ignored.
- CAPTURE: each i_adc_valid cycle is a write attempt.
  - If the FIFO is not full, write {last, packed word}. Decrement the remaining counter. last=1 when remaining==1.
  - If the FIFO is full, drop the sample, set o_overflow, and leave the counter unchanged.
  - Result: a frame always carries exactly i_frame_len words.
  - On the write with remaining==1, go DRAIN.
- DRAIN: stay until the FIFO is empty and no word is pending on the output. Then pulse o_done for one cycle and go IDLE.
- i_start is ignored in CAPTURE and DRAIN. i_adc_valid is ignored in IDLE and DRAIN.
- Full is evaluated on the registered occupancy before this cycle's read. A write while full is dropped even if a read completes in the same cycle.
- FIFO read: a word leaves on o_data_valid && i_data_ready. o_data and o_data_last are held stable while o_data_valid && !i_data_ready. o_data_valid never deasserts without a handshake.
- Reset (async assert, released synchronously to i_sys_clock):
  - FSM=IDLE, FIFO empty, counter=0.
  - All outputs 0: o_data, o_data_valid, o_data_last, o_busy, o_done, o_overflow.
  - Reset mid-frame discards FIFO contents and emits no tlast.

## Timing
- Latency: a sample written at edge N into an empty FIFO gives o_data_valid=1 after edge N+1. The output is registered.
- Throughput: one word per cycle when i_data_ready is held high. With continuous i_adc_valid there is no overflow under that condition.
- o_busy rises the cycle after the accepted start and falls with the o_done cycle.
- o_done rises the cycle after the handshake of the tlast word.
- o_overflow stays set through IDLE until the next accepted start.

## Test plan
- Length 8, continuous valid, ready=1, ch1=0x1FFF..0x1FF8, ch2=0x2000+k → 8 words, first 0x7FFC8000, tlast only on word 8, o_done pulse, overflow=0.
- Length 40, continuous valid, ready=0 for the first 30 cycles → FIFO fills at 16 entries. Capture continues until 40 words are written, then all 40 words are delivered in order, tlast on word 40, overflow=1.
- Length 4, random ready toggling → o_data/tlast stable while valid&&!ready, 4 handshakes total, no duplicates.
- i_start during CAPTURE, and start with i_frame_len=0 in IDLE → both ignored; o_busy unchanged; frame length is the originally latched value.
- Assert i_nReset after 3 of 10 samples → all outputs 0 immediately, no tlast. A new start with length 2 then yields exactly 2 words.
- Full FIFO with a write and read in the same cycle → write dropped, overflow=1, occupancy decrements by 1.

Source files
------------

// File: rtl/adc_axis_packer.sv
// Two-channel ADC capture packer: frames a software-armed run of sample pairs into a
// 32-bit AXI-Stream, buffered by a small FIFO and a registered output stage.
module adc_axis_packer #(
    parameter int ZMOD_DATA_SIZE = 14,
    parameter int AXIS_DATA_SIZE = 32,
    parameter int FIFO_DEPTH     = 16,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                      i_sys_clock,
    input  logic                      i_nReset,
    input  logic [ZMOD_DATA_SIZE-1:0] i_adc_ch1,
    input  logic [ZMOD_DATA_SIZE-1:0] i_adc_ch2,
    input  logic                      i_adc_valid,
    input  logic                      i_start,
    input  logic [LEN_WIDTH-1:0]      i_frame_len,
    output logic [AXIS_DATA_SIZE-1:0] o_data,
    output logic                      o_data_valid,
    input  logic                      i_data_ready,
    output logic                      o_data_last,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_overflow,
    output logic [1:0]                o_fsm_state
);

    localparam int LANE = AXIS_DATA_SIZE / 2;
    localparam int PAD  = LANE - ZMOD_DATA_SIZE;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int EW   = AXIS_DATA_SIZE + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    // Output stream handshake: a word transfers on a clock edge where o_data_valid and
    // i_data_ready are both high; while valid is high and ready low, o_data/o_data_last
    // hold, and valid only drops after a transfer.

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [LEN_WIDTH-1:0]      remaining;
    logic [AXIS_DATA_SIZE-1:0] packed_word;
    logic [EW-1:0]             fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [CW-1:0]             fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      start_accept;
    logic                      write_attempt;
    logic                      fifo_wr;
    logic                      fifo_rd;
    logic                      write_last;
    logic                      out_handshake;
    logic                      last_handshake;
    logic                      overflow_q;
    logic                      done_q;
    logic [AXIS_DATA_SIZE-1:0] out_data;
    logic                      out_valid;
    logic                      out_last;

    // Samples sit in the top bits of each 16-bit lane; the low pad bits stay zero.
    assign packed_word = (AXIS_DATA_SIZE'(i_adc_ch1) << (LANE + PAD))
                       | (AXIS_DATA_SIZE'(i_adc_ch2) << PAD);

    assign fifo_full      = (fifo_count == FULL_COUNT);
    assign fifo_empty     = (fifo_count == '0);
    assign start_accept   = (state == ST_IDLE) && i_start && (i_frame_len != '0);
    assign write_attempt  = (state == ST_CAPTURE) && i_adc_valid;
    assign fifo_wr        = write_attempt && !fifo_full;
    assign write_last     = fifo_wr && (remaining == LEN_WIDTH'(1));
    assign out_handshake  = out_valid && i_data_ready;
    assign last_handshake = out_handshake && out_last;
    assign fifo_rd        = !fifo_empty && (!out_valid || i_data_ready);

    always_ff @(posedge i_sys_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_accept) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (write_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The tlast word is the last one written, so its transfer empties the path.
                if (last_handshake) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (state != ST_IDLE);
        o_fsm_state = state;
    end

    always_ff @(posedge i_sys_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            remaining  <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state == ST_DRAIN) && last_handshake;
            if (start_accept) begin
                remaining  <= i_frame_len;
                overflow_q <= 1'b0;
            end else if (fifo_wr) begin
                remaining <= remaining - LEN_WIDTH'(1);
            end else if (write_attempt) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_sys_clock) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= {write_last, packed_word};
        end
    end

    always_ff @(posedge i_sys_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge i_sys_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (fifo_rd) begin
            out_valid <= 1'b1;
            out_last  <= fifo_mem[rd_ptr][EW-1];
            out_data  <= fifo_mem[rd_ptr][AXIS_DATA_SIZE-1:0];
        end else if (out_handshake) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    assign o_data       = out_data;
    assign o_data_valid = out_valid;
    assign o_data_last  = out_last;
    assign o_done       = done_q;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_adc_axis_packer.sv
// Bench for adc_axis_packer: random framed captures scored as ordered subsequences of the
// offered samples, plus directed backpressure, ignored-start and mid-frame reset cases.
module tb_adc_axis_packer;

    localparam int Z = 14;
    localparam int A = 32;
    localparam int L = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [Z-1:0]  ch1, ch2;
    logic          adc_valid, start, ready;
    logic [L-1:0]  frame_len;
    logic [A-1:0]  data;
    logic          data_valid, data_last, busy, done, overflow;
    logic [1:0]    fsm_state;

    adc_axis_packer #(.ZMOD_DATA_SIZE(Z), .AXIS_DATA_SIZE(A), .FIFO_DEPTH(16), .LEN_WIDTH(L)) dut (
        .i_sys_clock(clk), .i_nReset(rst_n), .i_adc_ch1(ch1), .i_adc_ch2(ch2),
        .i_adc_valid(adc_valid), .i_start(start), .i_frame_len(frame_len),
        .o_data(data), .o_data_valid(data_valid), .i_data_ready(ready),
        .o_data_last(data_last), .o_busy(busy), .o_done(done), .o_overflow(overflow),
        .o_fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [A-1:0] exp_q[$];
    logic [A-1:0] delivered_q[$];
    int           cur_len, words, skips;
    bit           done_pending, done_seen;
    bit           in_reset = 1'b1;
    bit           prev_stall;
    logic [A-1:0] prev_data;
    logic         prev_last;
    logic [A-1:0] same_cycle_val;

    function automatic logic [A-1:0] pack(input logic [Z-1:0] c1, input logic [Z-1:0] c2);
        return {c1, 2'b00, c2, 2'b00};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard: samples away from the active edge.
    always @(negedge clk) begin
        if (!in_reset) begin
            if (prev_stall) begin
                check("hold_valid", data_valid, 1'b1);
                check("hold_data", data, prev_data);
                check("hold_last", data_last, prev_last);
            end
            if (done || done_pending) begin
                check("done_pulse", done, done_pending);
                check("busy_on_done", busy, 1'b0);
            end
            if (done_pending) begin
                done_pending = 1'b0;
                done_seen    = 1'b1;
            end
            if (data_valid && ready) begin
                while (exp_q.size() > 0 && exp_q[0] !== data) begin
                    void'(exp_q.pop_front());
                    skips++;
                end
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got 0x%08h, required no word", data);
                end else begin
                    void'(exp_q.pop_front());
                    tests++;
                    words++;
                    delivered_q.push_back(data);
                    check("tlast", data_last, (words == cur_len));
                    if (data_last) done_pending = 1'b1;
                end
            end
            prev_stall = data_valid && !ready;
            prev_data  = data;
            prev_last  = data_last;
        end else begin
            prev_stall   = 1'b0;
            done_pending = 1'b0;
        end
    end

    task automatic drive_idle();
        adc_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic offer_sample(input int k, input bit pattern);
        logic [Z-1:0] c1, c2;
        if (pattern) begin
            c1 = Z'(14'h1FFF - k);
            c2 = Z'(14'h2000 + k);
        end else begin
            c1 = Z'($urandom);
            c2 = Z'(k);
        end
        ch1       = c1;
        ch2       = c2;
        adc_valid = 1'b1;
        exp_q.push_back(pack(c1, c2));
    endtask

    // Called at posedge+1; returns at posedge+1 of the first capture cycle.
    task automatic start_frame(input int len);
        cur_len = len;
        words   = 0;
        skips   = 0;
        done_seen = 1'b0;
        exp_q.delete();
        delivered_q.delete();
        start     = 1'b1;
        frame_len = L'(len);
        @(posedge clk); #1;
        start     = 1'b0;
        frame_len = L'($urandom);
        check("busy_after_start", busy, 1'b1);
        check("overflow_cleared", overflow, 1'b0);
    endtask

    task automatic run_frame(input int len, input int valid_pct, input int ready_pct,
                             input int stall, input bit pattern, input int restart_at,
                             output int skips_out);
        int cyc = 0;
        int k = 0;
        start_frame(len);
        while (!done_seen && cyc < 3000) begin
            if (cyc < stall) ready = 1'b0;
            else if (ready_pct >= 100) ready = 1'b1;
            else ready = ($urandom_range(99) < ready_pct);
            if ($urandom_range(99) < valid_pct) begin
                offer_sample(k, pattern);
                if (stall > 0 && cyc == stall) same_cycle_val = exp_q[$];
                k++;
            end else begin
                adc_valid = 1'b0;
            end
            if (cyc == restart_at) begin
                start     = 1'b1;
                frame_len = L'(3);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (cyc == restart_at) check("busy_kept_on_restart", busy, 1'b1);
            cyc++;
        end
        drive_idle();
        ready = 1'b1;
        if (!done_seen) begin
            tests++;
            fails++;
            $display("FAIL frame_timeout: got %0d words, required %0d", words, len);
        end
        check("frame_words", words, len);
        check("overflow_flag", overflow, (skips > 0));
        skips_out = skips;
    endtask

    initial begin
        int sk;
        bit found;
        rst_n = 1'b0;
        ch1 = '0; ch2 = '0; frame_len = '0; ready = 1'b1;
        drive_idle();
        #1;
        check("rst_data", data, 0);
        check("rst_valid", data_valid, 0);
        check("rst_last", data_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_state", fsm_state, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        in_reset = 1'b0;
        @(posedge clk); #1;

        // Length 8, continuous valid, ready high.
        run_frame(8, 100, 100, 0, 1'b1, -1, sk);
        check("t1_no_skips", sk, 0);
        check("t1_first_word", delivered_q[0], 32'h7FFC_8000);
        check("t1_last_word", delivered_q[7], pack(14'h1FF8, 14'h2007));

        // Length 40, ready low for 30 cycles.
        run_frame(40, 100, 100, 30, 1'b0, -1, sk);
        check("t2_overflow_skips", (sk > 0), 1'b1);
        found = 1'b0;
        foreach (delivered_q[i]) if (delivered_q[i] === same_cycle_val) found = 1'b1;
        check("t2_full_rd_wr_dropped", found, 1'b0);
        repeat (3) @(posedge clk);
        #1 check("t2_overflow_sticky_idle", overflow, 1'b1);

        // Length 4 with random ready.
        run_frame(4, 100, 50, 0, 1'b0, -1, sk);
        check("t3_no_skips", sk, 0);

        // Start during capture ignored; then zero-length start in idle ignored.
        run_frame(6, 100, 100, 0, 1'b0, 2, sk);
        check("t4_no_skips", sk, 0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        frame_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_len_busy", busy, 1'b0);
        check("zero_len_state", fsm_state, 0);
        repeat (3) @(posedge clk);
        #1 check("zero_len_no_output", data_valid, 1'b0);

        // Reset after 3 of 10 samples.
        start_frame(10);
        for (int i = 0; i < 3; i++) begin
            offer_sample(i, 1'b0);
            @(posedge clk); #1;
        end
        drive_idle();
        #2;
        in_reset = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", data, 0);
        check("mid_rst_valid", data_valid, 0);
        check("mid_rst_last", data_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_overflow", overflow, 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("post_rst_no_output", data_valid, 1'b0);
        run_frame(2, 100, 100, 0, 1'b0, -1, sk);
        check("post_rst_no_skips", sk, 0);

        // Random frames.
        for (int f = 0; f < 8; f++) begin
            run_frame($urandom_range(24, 1), $urandom_range(100, 40), $urandom_range(100, 30),
                      0, 1'b0, -1, sk);
            repeat ($urandom_range(3)) @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
